// File: rtl/bf16_accum_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bf16_accum_seq_pkg
// Description : Shared bf16 constants and the accumulator state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bf16_accum_seq_pkg;

    localparam logic [15:0] BF16_QNAN  = 16'h7FC0;
    localparam logic [15:0] BF16_PINF  = 16'h7F80;
    localparam logic [15:0] BF16_NINF  = 16'hFF80;
    localparam logic [15:0] BF16_PZERO = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bf16_accum_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module      : bf16_accum_seq_addsub
// Description : Combinational bf16 adder/subtractor, C = A + B (inst=1) or
//               C = A - B (inst=0). Round-to-nearest-even, subnormal inputs
//               and results flush to zero, any NaN input gives the quiet NaN.
// Ports       : inst  in  1   1: add, 0: subtract
//               A     in  16  left operand (accumulator)
//               B     in  16  right operand (element)
//               C     out 16  result
// Revision    : 1.0 - initial release
// ============================================================================
module bf16_accum_seq_addsub
    import bf16_accum_seq_pkg::*;
(
    input  logic        inst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] C
);

    logic              w_sa, w_sb, w_sx, w_sy;
    logic [7:0]        w_ea, w_eb, w_ex, w_ey;
    logic [7:0]        w_ma, w_mb, w_mx, w_my;
    logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic [7:0]        w_d;
    logic [3:0]        w_shamt;
    logic [21:0]       w_algn;
    logic [10:0]       w_mxe, w_mye;
    logic [11:0]       w_sum;
    logic [10:0]       w_norm;
    logic [3:0]        w_lz;
    logic signed [9:0] w_exp, w_exp_r;
    logic              w_up;
    logic [7:0]        w_rnd;

    always_comb begin
        w_sa    = A[15];
        w_sb    = B[15] ^ ~inst;
        w_ea    = A[14:7];
        w_eb    = B[14:7];
        w_nan_a = (w_ea == 8'hFF) && (A[6:0] != 7'd0);
        w_nan_b = (w_eb == 8'hFF) && (B[6:0] != 7'd0);
        w_inf_a = (w_ea == 8'hFF) && (A[6:0] == 7'd0);
        w_inf_b = (w_eb == 8'hFF) && (B[6:0] == 7'd0);
        w_ma    = (w_ea == 8'd0) ? 8'h00 : {1'b1, A[6:0]};
        w_mb    = (w_eb == 8'd0) ? 8'h00 : {1'b1, B[6:0]};

        // X is the operand of larger magnitude; the result takes its sign.
        if ({w_ea, w_ma} >= {w_eb, w_mb}) begin
            w_sx = w_sa; w_ex = w_ea; w_mx = w_ma;
            w_sy = w_sb; w_ey = w_eb; w_my = w_mb;
        end else begin
            w_sx = w_sb; w_ex = w_eb; w_mx = w_mb;
            w_sy = w_sa; w_ey = w_ea; w_my = w_ma;
        end

        // Align Y with three extra bits (guard, round, sticky); shifts past
        // the window fold everything into sticky.
        w_d     = w_ex - w_ey;
        w_shamt = (w_d > 8'd11) ? 4'd11 : w_d[3:0];
        w_algn  = {w_my, 14'b0} >> w_shamt;
        w_mxe   = {w_mx, 3'b000};
        w_mye   = {w_algn[21:12], w_algn[11] | (|w_algn[10:0])};

        w_lz  = 4'd0;
        w_exp = {2'b00, w_ex};
        if (w_sx == w_sy) begin
            w_sum = {1'b0, w_mxe} + {1'b0, w_mye};
            if (w_sum[11]) begin
                w_norm = {w_sum[11:2], w_sum[1] | w_sum[0]};
                w_exp  = w_exp + 10'sd1;
            end else begin
                w_norm = w_sum[10:0];
            end
        end else begin
            w_sum = {1'b0, w_mxe - w_mye};
            // Highest set bit wins, giving the leading-zero count.
            for (int i = 0; i <= 10; i++) begin
                if (w_sum[i]) w_lz = 4'(10 - i);
            end
            w_norm = w_sum[10:0] << w_lz;
            w_exp  = w_exp - {6'b0, w_lz};
        end

        // Round to nearest even; a carry out of the fraction bumps the exponent
        // and leaves an all-zero fraction.
        w_up    = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
        w_rnd   = {1'b0, w_norm[9:3]} + {7'b0, w_up};
        w_exp_r = w_rnd[7] ? (w_exp + 10'sd1) : w_exp;

        if (w_nan_a || w_nan_b)
            C = BF16_QNAN;
        else if (w_inf_a && w_inf_b)
            C = (w_sa != w_sb) ? BF16_QNAN : {w_sa, BF16_PINF[14:0]};
        else if (w_inf_a)
            C = {w_sa, BF16_PINF[14:0]};
        else if (w_inf_b)
            C = {w_sb, BF16_PINF[14:0]};
        else if (w_norm == 11'd0)
            C = {w_sx & w_sy, 15'b0};
        else if (w_exp_r >= 10'sd255)
            C = {w_sx, BF16_PINF[14:0]};
        else if (w_exp_r <= 10'sd0)
            C = {w_sx, 15'b0};
        else
            C = {w_sx, w_exp_r[7:0], w_rnd[6:0]};
    end

endmodule
`default_nettype wire

// File: rtl/bf16_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : bf16_accum_seq
// Description : Streaming bf16 accumulator. Folds a valid/ready stream of
//               bf16 elements into a running sum and presents the sum plus a
//               saturating element count when the last element arrives.
// Ports       : clk_i, rst_i (async, active-high), flush_i (sync abort)
//               in_valid_i/in_ready_o/in_data_i/in_sub_i/in_last_i : stream
//               out_valid_o/out_ready_i/out_data_o/out_count_o/out_ovf_o
// Parameters  : PIPE  - 0: one element/cycle, 1: operand regs, 2 cycles/elem
//               CNT_W - element counter width
// Revision    : 1.0 - initial release
// ============================================================================
module bf16_accum_seq
    import bf16_accum_seq_pkg::*;
#(
    parameter int PIPE  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      in_data_i,
    input  logic             in_sub_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [15:0]      out_data_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_ovf_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t           r_state;
    logic [15:0]      r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic             w_accept;
    logic [15:0]      w_load;
    logic [15:0]      w_add_a, w_add_b, w_add_c;
    logic             w_add_inst;
    logic             w_op_last;

    assign in_ready_o  = ~rst_i & ((r_state == IDLE) | (r_state == ACC));
    assign w_accept    = in_valid_i & in_ready_o;
    // First element bypasses the adder; subtraction just flips its sign.
    assign w_load      = {in_data_i[15] ^ in_sub_i, in_data_i[14:0]};
    assign out_valid_o = (r_state == DONE);
    assign out_data_o  = r_acc;
    assign out_count_o = r_count;
    assign out_ovf_o   = r_ovf;

    generate
        if (PIPE != 0) begin : g_pipe
            logic [15:0] r_op_a, r_op_b;
            logic        r_op_inst, r_op_last;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i || flush_i) begin
                    r_op_a    <= BF16_PZERO;
                    r_op_b    <= BF16_PZERO;
                    r_op_inst <= 1'b0;
                    r_op_last <= 1'b0;
                end else if (w_accept && (r_state == ACC)) begin
                    r_op_a    <= r_acc;
                    r_op_b    <= in_data_i;
                    r_op_inst <= ~in_sub_i;
                    r_op_last <= in_last_i;
                end
            end

            assign w_add_a    = r_op_a;
            assign w_add_b    = r_op_b;
            assign w_add_inst = r_op_inst;
            assign w_op_last  = r_op_last;
        end else begin : g_nopipe
            assign w_add_a    = r_acc;
            assign w_add_b    = in_data_i;
            assign w_add_inst = ~in_sub_i;
            assign w_op_last  = 1'b0;
        end
    endgenerate

    bf16_accum_seq_addsub u_addsub (
        .inst (w_add_inst),
        .A    (w_add_a),
        .B    (w_add_b),
        .C    (w_add_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            r_state <= IDLE;
            r_acc   <= BF16_PZERO;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc   <= w_load;
                        r_count <= CNT_W'(1);
                        r_state <= in_last_i ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        if (r_count == c_cnt_max) r_ovf <= 1'b1;
                        else                      r_count <= r_count + CNT_W'(1);
                        if (PIPE != 0) begin
                            r_state <= WAIT;
                        end else begin
                            r_acc   <= w_add_c;
                            r_state <= in_last_i ? DONE : ACC;
                        end
                    end
                end
                WAIT: begin
                    r_acc   <= w_add_c;
                    r_state <= w_op_last ? DONE : ACC;
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_acc   <= BF16_PZERO;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bf16_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf16_accum_seq
// Description : Directed bench for bf16_accum_seq. Instance a: PIPE=0,
//               CNT_W=8. Instance b: PIPE=1, CNT_W=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bf16_accum_seq;

    logic        clk, rst;
    logic        a_flush, a_in_valid, a_in_ready, a_in_sub, a_in_last;
    logic        a_out_valid, a_out_ready, a_out_ovf;
    logic [15:0] a_in_data, a_out_data;
    logic [7:0]  a_out_count;
    logic        b_flush, b_in_valid, b_in_ready, b_in_sub, b_in_last;
    logic        b_out_valid, b_out_ready, b_out_ovf;
    logic [15:0] b_in_data, b_out_data;
    logic [1:0]  b_out_count;

    int n_asserts = 0;
    int n_fail    = 0;

    bf16_accum_seq #(.PIPE(0), .CNT_W(8)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
        .in_sub_i(a_in_sub), .in_last_i(a_in_last),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .out_data_o(a_out_data), .out_count_o(a_out_count), .out_ovf_o(a_out_ovf)
    );

    bf16_accum_seq #(.PIPE(1), .CNT_W(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .in_sub_i(b_in_sub), .in_last_i(b_in_last),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_data_o(b_out_data), .out_count_o(b_out_count), .out_ovf_o(b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [15:0] d, input logic s, input logic l);
        a_in_valid = 1'b1; a_in_data = d; a_in_sub = s; a_in_last = l;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_sub = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic res_a(input string tag, input logic [15:0] d, input logic [7:0] c, input logic o);
        chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
        chk({tag, "_data"},  32'(a_out_data),  32'(d));
        chk({tag, "_count"}, 32'(a_out_count), 32'(c));
        chk({tag, "_ovf"},   32'(a_out_ovf),   32'(o));
    endtask

    task automatic consume_a(input string tag);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk({tag, "_done_valid"}, 32'(a_out_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(a_in_ready),  32'd1);
    endtask

    initial begin
        logic e_rdy;
        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 16'h0; a_in_sub = 1'b0;
        a_in_last = 1'b0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 16'h0; b_in_sub = 1'b0;
        b_in_last = 1'b0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(a_out_valid), 32'd0);
        chk("rst_data",  32'(a_out_data),  32'h0);
        chk("rst_count", 32'(a_out_count), 32'd0);
        chk("rst_ovf",   32'(a_out_ovf),   32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(a_in_ready), 32'd1);

        // T1: 1 + 1 + 1
        @(posedge clk); #1;
        send_a(16'h3F80, 1'b0, 1'b0);
        send_a(16'h3F80, 1'b0, 1'b0);
        chk("t1_no_early_valid", 32'(a_out_valid), 32'd0);
        send_a(16'h3F80, 1'b0, 1'b1);
        res_a("t1", 16'h4040, 8'd3, 1'b0);
        chk("t1_ready_in_done", 32'(a_in_ready), 32'd0);
        consume_a("t1");

        // T2: 2 - 0.5, then a lone subtracted element
        send_a(16'h4000, 1'b0, 1'b0);
        send_a(16'h3F00, 1'b1, 1'b1);
        res_a("t2_sub", 16'h3FC0, 8'd2, 1'b0);
        consume_a("t2_sub");
        send_a(16'h3F80, 1'b1, 1'b1);
        res_a("t2_single", 16'hBF80, 8'd1, 1'b0);
        consume_a("t2_single");

        // T3: special values
        send_a(16'h7F80, 1'b0, 1'b0);
        send_a(16'hFF80, 1'b0, 1'b1);
        res_a("t3_inf_minf", 16'h7FC0, 8'd2, 1'b0);
        consume_a("t3_inf_minf");
        send_a(16'h7FC1, 1'b0, 1'b0);
        send_a(16'h3F80, 1'b0, 1'b1);
        res_a("t3_nan", 16'h7FC0, 8'd2, 1'b0);
        consume_a("t3_nan");
        send_a(16'h3F80, 1'b0, 1'b0);
        send_a(16'h7F80, 1'b0, 1'b1);
        res_a("t3_one_inf", 16'h7F80, 8'd2, 1'b0);

        // T4: backpressure, with an element offered while the result waits
        a_in_valid = 1'b1; a_in_data = 16'h3F80; a_in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            res_a("t4_hold", 16'h7F80, 8'd2, 1'b0);
            chk("t4_hold_ready", 32'(a_in_ready), 32'd0);
        end
        a_in_valid = 1'b0; a_in_last = 1'b0;
        consume_a("t4");

        // T5: flush mid-stream discards the concurrent element
        send_a(16'h3F80, 1'b0, 1'b0);
        send_a(16'h4000, 1'b0, 1'b0);
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 16'h4040; a_in_last = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_last = 1'b0;
        chk("t5_flush_valid", 32'(a_out_valid), 32'd0);
        chk("t5_flush_ready", 32'(a_in_ready),  32'd1);
        send_a(16'h3F00, 1'b0, 1'b1);
        res_a("t5_after", 16'h3F00, 8'd1, 1'b0);
        consume_a("t5");

        // T6: PIPE=1, CNT_W=2, five ones with in_valid held high
        b_in_valid = 1'b1; b_in_data = 16'h3F80; b_in_sub = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e_rdy = (i == 0) || (i % 2 == 1);
            chk("t6_ready", 32'(b_in_ready), 32'(e_rdy));
            b_in_last = (i == 7);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0; b_in_last = 1'b0;
        chk("t6_wait_valid", 32'(b_out_valid), 32'd0);
        @(posedge clk); #1;
        chk("t6_valid", 32'(b_out_valid), 32'd1);
        chk("t6_data",  32'(b_out_data),  32'h40A0);
        chk("t6_count", 32'(b_out_count), 32'd3);
        chk("t6_ovf",   32'(b_out_ovf),   32'd1);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("t6_done_valid", 32'(b_out_valid), 32'd0);
        chk("t6_ovf_clear",  32'(b_out_ovf),   32'd0);
        chk("t6_done_ready", 32'(b_in_ready),  32'd1);

        // Asynchronous reset while a result is pending (no clock edge seen)
        send_a(16'h3F80, 1'b0, 1'b1);
        res_a("ar_pre", 16'h3F80, 8'd1, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(a_out_valid), 32'd0);
        chk("ar_data",  32'(a_out_data),  32'h0);
        chk("ar_count", 32'(a_out_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Asynchronous reset mid-stream: nothing carries into the next stream
        send_a(16'h3F80, 1'b0, 1'b0);
        send_a(16'h3F80, 1'b0, 1'b0);
        b_in_valid = 1'b1; b_in_data = 16'h4000;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("ar_mid_a_count", 32'(a_out_count), 32'd0);
        chk("ar_mid_b_count", 32'(b_out_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        send_a(16'h3F00, 1'b0, 1'b1);
        res_a("ar_mid_after", 16'h3F00, 8'd1, 1'b0);
        consume_a("ar_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
